// File: rtl/crono_countdown_ctrl_pkg.sv
// Shared types, field widths and limits for the chronometer countdown sequencer
// and the blocks that reuse its hh:mm:ss arithmetic.
package crono_countdown_ctrl_pkg;

  localparam int HORA_W = 4;
  localparam int MS_W   = 6;

  localparam logic [MS_W-1:0] MAX_MIN = 6'd59;
  localparam logic [MS_W-1:0] MAX_SEG = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    RING  = 2'd3
  } crono_state_e;

  function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] val,
                                                input logic [MS_W-1:0] lim);
    logic [MS_W-1:0] res;
    if (val > lim) res = lim;
    else           res = val;
    return res;
  endfunction

endpackage

// File: rtl/crono_countdown_ctrl_if.sv
// Button/tick/preset inputs and countdown/status outputs of the countdown sequencer.
interface crono_countdown_ctrl_if;
  import crono_countdown_ctrl_pkg::*;

  logic              tick_1hz;
  logic              sw_cronometro;
  logic              start_stop;
  logic              clear;
  logic              alarm_ack;
  logic [HORA_W-1:0] preset_hora;
  logic [MS_W-1:0]   preset_min;
  logic [MS_W-1:0]   preset_seg;
  logic [HORA_W-1:0] cnt_hora;
  logic [MS_W-1:0]   cnt_min;
  logic [MS_W-1:0]   cnt_seg;
  logic              running;
  logic              paused;
  logic              alarm;
  logic [1:0]        estado;

  modport master (
    output tick_1hz, sw_cronometro, start_stop, clear, alarm_ack,
           preset_hora, preset_min, preset_seg,
    input  cnt_hora, cnt_min, cnt_seg, running, paused, alarm, estado
  );

  modport slave (
    input  tick_1hz, sw_cronometro, start_stop, clear, alarm_ack,
           preset_hora, preset_min, preset_seg,
    output cnt_hora, cnt_min, cnt_seg, running, paused, alarm, estado
  );

endinterface

// File: rtl/crono_borrow_dec.sv
// Combinational hh:mm:ss decrement with borrow; flags a 00:00:00 result.
// A 00:00:00 input is held rather than wrapped.
module crono_borrow_dec
  import crono_countdown_ctrl_pkg::*;
(
  input  logic [HORA_W-1:0] hora,
  input  logic [MS_W-1:0]   min,
  input  logic [MS_W-1:0]   seg,
  output logic [HORA_W-1:0] hora_dec,
  output logic [MS_W-1:0]   min_dec,
  output logic [MS_W-1:0]   seg_dec,
  output logic              dec_zero
);

  logic in_zero_s;

  assign in_zero_s = (hora == 4'd0) && (min == 6'd0) && (seg == 6'd0);
  assign dec_zero  = (hora_dec == 4'd0) && (min_dec == 6'd0) && (seg_dec == 6'd0);

  // Borrow ripples seconds -> minutes -> hours.
  always_comb begin
    hora_dec = hora;
    min_dec  = min;
    seg_dec  = seg;
    if (in_zero_s) begin
      seg_dec = 6'd0;
    end else if (seg != 6'd0) begin
      seg_dec = seg - 6'd1;
    end else begin
      seg_dec = MAX_SEG;
      if (min != 6'd0) begin
        min_dec = min - 6'd1;
      end else begin
        min_dec  = MAX_MIN;
        hora_dec = hora - 4'd1;
      end
    end
  end

endmodule

// File: rtl/crono_countdown_ctrl.sv
// Countdown sequencer: loads the sanitised preset, counts down on tick_1hz,
// rings for RING_SECS ticks at expiry; adjust mode locks out counting.
module crono_countdown_ctrl
  import crono_countdown_ctrl_pkg::*;
#(
  parameter int RING_SECS = 10,
  parameter int MAX_HORA  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  crono_countdown_ctrl_if.slave bus
);

  localparam logic [HORA_W-1:0] MAX_HORA_V = HORA_W'(MAX_HORA);
  localparam logic [5:0]        RING_LAST  = 6'(RING_SECS);

  crono_state_e      state_r, state_nxt_s;
  logic [HORA_W-1:0] hora_r, hora_nxt_s, hora_san_s, hora_dec_s;
  logic [MS_W-1:0]   min_r, min_nxt_s, min_san_s, min_dec_s;
  logic [MS_W-1:0]   seg_r, seg_nxt_s, seg_san_s, seg_dec_s;
  logic [5:0]        ring_r, ring_nxt_s;
  logic              running_r, paused_r, alarm_r;
  logic              preset_zero_s, dec_zero_s;

  assign hora_san_s    = (bus.preset_hora > MAX_HORA_V) ? MAX_HORA_V : bus.preset_hora;
  assign min_san_s     = clamp_ms(bus.preset_min, MAX_MIN);
  assign seg_san_s     = clamp_ms(bus.preset_seg, MAX_SEG);
  assign preset_zero_s = (hora_san_s == 4'd0) && (min_san_s == 6'd0) && (seg_san_s == 6'd0);

  crono_borrow_dec u_dec (
    .hora     (hora_r),
    .min      (min_r),
    .seg      (seg_r),
    .hora_dec (hora_dec_s),
    .min_dec  (min_dec_s),
    .seg_dec  (seg_dec_s),
    .dec_zero (dec_zero_s)
  );

  // Next state and count; any entry into IDLE reloads the sanitised preset.
  always_comb begin
    state_nxt_s = state_r;
    hora_nxt_s  = hora_r;
    min_nxt_s   = min_r;
    seg_nxt_s   = seg_r;
    ring_nxt_s  = ring_r;
    case (state_r)
      IDLE: begin
        hora_nxt_s = hora_san_s;
        min_nxt_s  = min_san_s;
        seg_nxt_s  = seg_san_s;
        ring_nxt_s = 6'd0;
        if (bus.clear || bus.sw_cronometro)             state_nxt_s = IDLE;
        else if (bus.start_stop && !preset_zero_s)      state_nxt_s = RUN;
        else                                            state_nxt_s = IDLE;
      end
      RUN: begin
        if (bus.clear) begin
          state_nxt_s = IDLE;
          hora_nxt_s  = hora_san_s;
          min_nxt_s   = min_san_s;
          seg_nxt_s   = seg_san_s;
        end else if (bus.sw_cronometro || bus.start_stop) begin
          state_nxt_s = PAUSE;
        end else if (bus.tick_1hz) begin
          hora_nxt_s = hora_dec_s;
          min_nxt_s  = min_dec_s;
          seg_nxt_s  = seg_dec_s;
          if (dec_zero_s) begin
            state_nxt_s = RING;
            ring_nxt_s  = 6'd0;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      PAUSE: begin
        if (bus.clear) begin
          state_nxt_s = IDLE;
          hora_nxt_s  = hora_san_s;
          min_nxt_s   = min_san_s;
          seg_nxt_s   = seg_san_s;
        end else if (bus.start_stop && !bus.sw_cronometro) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = PAUSE;
        end
      end
      RING: begin
        hora_nxt_s = 4'd0;
        min_nxt_s  = 6'd0;
        seg_nxt_s  = 6'd0;
        if (bus.clear || bus.alarm_ack || bus.start_stop ||
            (bus.tick_1hz && (ring_r + 6'd1 == RING_LAST))) begin
          state_nxt_s = IDLE;
          ring_nxt_s  = 6'd0;
          hora_nxt_s  = hora_san_s;
          min_nxt_s   = min_san_s;
          seg_nxt_s   = seg_san_s;
        end else if (bus.tick_1hz) begin
          ring_nxt_s = ring_r + 6'd1;
        end else begin
          state_nxt_s = RING;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        hora_nxt_s  = 4'd0;
        min_nxt_s   = 6'd0;
        seg_nxt_s   = 6'd0;
        ring_nxt_s  = 6'd0;
      end
    endcase
  end

  // State, count, ring counter and decoded status flags update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      hora_r    <= 4'd0;
      min_r     <= 6'd0;
      seg_r     <= 6'd0;
      ring_r    <= 6'd0;
      running_r <= 1'b0;
      paused_r  <= 1'b0;
      alarm_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      hora_r    <= hora_nxt_s;
      min_r     <= min_nxt_s;
      seg_r     <= seg_nxt_s;
      ring_r    <= ring_nxt_s;
      running_r <= (state_nxt_s == RUN);
      paused_r  <= (state_nxt_s == PAUSE);
      alarm_r   <= (state_nxt_s == RING);
    end
  end

  assign bus.cnt_hora = hora_r;
  assign bus.cnt_min  = min_r;
  assign bus.cnt_seg  = seg_r;
  assign bus.running  = running_r;
  assign bus.paused   = paused_r;
  assign bus.alarm    = alarm_r;
  assign bus.estado   = state_r;

endmodule

// File: tb/tb_crono_countdown_ctrl.sv
// Bench for crono_countdown_ctrl: vector table, hand-written corner sequences,
// then random stimulus against a seconds-based reference model.
module tb_crono_countdown_ctrl;

  localparam int RING_SECS = 10;
  localparam int MAX_HORA  = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Reference model: remaining time kept as a plain count of seconds.
  int m_state = 0;
  int m_secs  = 0;
  int m_ring  = 0;

  crono_countdown_ctrl_if bus_if ();

  crono_countdown_ctrl #(.RING_SECS(RING_SECS), .MAX_HORA(MAX_HORA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ss, tk, clr, sw, ack;
    int   ph, pm, ps;
    int   eh, em, es, est;
    bit   chk_cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic int preset_secs();
    int h, m, s;
    h = int'(bus_if.preset_hora);
    m = int'(bus_if.preset_min);
    s = int'(bus_if.preset_seg);
    if (h > MAX_HORA) h = MAX_HORA;
    if (m > 59) m = 59;
    if (s > 59) s = 59;
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_secs  = 0;
    m_ring  = 0;
  endtask

  task automatic model_step();
    int p;
    p = preset_secs();
    case (m_state)
      0: begin
        m_secs = p;
        if (!bus_if.clear && !bus_if.sw_cronometro && bus_if.start_stop && p != 0) m_state = 1;
      end
      1: begin
        if (bus_if.clear) begin
          m_state = 0; m_secs = p;
        end else if (bus_if.sw_cronometro || bus_if.start_stop) begin
          m_state = 2;
        end else if (bus_if.tick_1hz) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_state = 3; m_ring = 0; end
        end
      end
      2: begin
        if (bus_if.clear) begin
          m_state = 0; m_secs = p;
        end else if (bus_if.start_stop && !bus_if.sw_cronometro) begin
          m_state = 1;
        end
      end
      default: begin
        if (bus_if.clear || bus_if.alarm_ack || bus_if.start_stop) begin
          m_state = 0; m_secs = p;
        end else if (bus_if.tick_1hz) begin
          m_ring = m_ring + 1;
          if (m_ring == RING_SECS) begin m_state = 0; m_secs = p; end
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic ss, input logic tk, input logic clr,
                       input logic sw, input logic ack);
    bus_if.start_stop    = ss;
    bus_if.tick_1hz      = tk;
    bus_if.clear         = clr;
    bus_if.sw_cronometro = sw;
    bus_if.alarm_ack     = ack;
  endtask

  task automatic set_preset(input int h, input int m, input int s);
    bus_if.preset_hora = 4'(h);
    bus_if.preset_min  = 6'(m);
    bus_if.preset_seg  = 6'(s);
  endtask

  task automatic step(input logic ss, input logic tk, input logic clr,
                      input logic sw, input logic ack);
    drive(ss, tk, clr, sw, ack);
    cycle();
    drive(1'b0, 1'b0, 1'b0, sw, 1'b0);
  endtask

  task automatic check_out(input string name, input int eh, input int em, input int es,
                           input int est, input bit chk_cnt);
    int gh, gm, gs, ge;
    logic [2:0] gf, ef;
    gh = int'(bus_if.cnt_hora);
    gm = int'(bus_if.cnt_min);
    gs = int'(bus_if.cnt_seg);
    ge = int'(bus_if.estado);
    gf = {bus_if.running, bus_if.paused, bus_if.alarm};
    ef = {est == 1, est == 2, est == 3};
    total++;
    if ((chk_cnt && (gh != eh || gm != em || gs != es)) || ge != est || gf != ef) begin
      bad++;
      $display("FAIL %s: got %0d:%0d:%0d estado=%0d run/pause/alarm=%b, expected %0d:%0d:%0d estado=%0d run/pause/alarm=%b (cnt checked=%0d)",
               name, gh, gm, gs, ge, gf, eh, em, es, est, ef, chk_cnt);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,  0, 1, 5,   0, 1, 5, 0, 1'b1};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,  0, 1, 5,   0, 1, 5, 1, 1'b1};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,  0, 1, 5,   0, 1, 4, 1, 1'b1};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,  0, 1, 5,   0, 1, 3, 1, 1'b1};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,  0, 1, 5,   0, 1, 2, 1, 1'b1};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,  0, 1, 5,   0, 1, 1, 1, 1'b1};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,  0, 1, 5,   0, 1, 0, 1, 1'b1};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,  0, 1, 5,   0, 0,59, 1, 1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,  0, 1, 5,   0, 0, 0, 0, 1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,  1, 0, 0,   1, 0, 0, 0, 1'b1};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,  1, 0, 0,   1, 0, 0, 1, 1'b1};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,  1, 0, 0,   0,59,59, 1, 1'b1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,  1, 0, 0,   0,59,59, 2, 1'b1};
    vecs[13] = '{1'b1,1'b1,1'b0,1'b1,1'b0,  1, 0, 0,   0,59,59, 2, 1'b1};
    vecs[14] = '{1'b1,1'b0,1'b1,1'b0,1'b0,  1, 0, 0,   0, 0, 0, 0, 1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,  0, 0, 0,   0, 0, 0, 0, 1'b1};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,  0, 0, 0,   0, 0, 0, 0, 1'b1};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 15,63,62,  15,59,59, 0, 1'b1};
    vecs[18] = '{1'b1,1'b0,1'b0,1'b1,1'b0,  0, 0, 5,   0, 0, 5, 0, 1'b1};
    vecs[19] = '{1'b1,1'b0,1'b0,1'b0,1'b0,  0, 0, 5,   0, 0, 5, 1, 1'b1};
    vecs[20] = '{1'b0,1'b0,1'b1,1'b0,1'b0,  0, 0, 5,   0, 0, 0, 0, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_preset(0, 0, 0);
    model_reset();
    #12;
    check_out("reset", 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      set_preset(vecs[i].ph, vecs[i].pm, vecs[i].ps);
      step(vecs[i].ss, vecs[i].tk, vecs[i].clr, vecs[i].sw, vecs[i].ack);
      check_out($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].est, vecs[i].chk_cnt);
    end

    // Expiry and ring duration; adjust switch toggled inside RING has no effect.
    set_preset(0, 0, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("ring_t1", 0, 0, 1, 1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("ring_enter", 0, 0, 0, 3, 1'b1);
    for (int k = 1; k <= RING_SECS; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k < RING_SECS) check_out($sformatf("ring_tick%0d", k), 0, 0, 0, 3, 1'b1);
      else               check_out("ring_done", 0, 0, 0, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause requested in the same cycle as a tick drops the tick.
    set_preset(0, 0, 30);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("pause_tick", 0, 0, 30, 2, 1'b1);
    for (int k = 0; k < 5; k++) begin
      set_preset(0, 0, 40 + k);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_out($sformatf("pause_hold%0d", k), 0, 0, 30, 2, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("resume", 0, 0, 30, 1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("resume_tick", 0, 0, 29, 1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RING.
    set_preset(0, 0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("pre_rst_ring", 0, 0, 0, 3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 1'b1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("post_rst1", 0, 0, 1, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("post_rst2", 0, 0, 1, 0, 1'b1);

    // Random stimulus against the reference model.
    for (int n = 0; n < 4000; n++) begin
      logic sw_lvl;
      sw_lvl = bus_if.sw_cronometro;
      if ($urandom_range(0, 49) == 0) sw_lvl = ~sw_lvl;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_preset($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63));
        else
          set_preset(0, $urandom_range(0, 1), $urandom_range(0, 4));
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
           sw_lvl, $urandom_range(0, 29) == 0);
      check_out("random", m_secs / 3600, (m_secs / 60) % 60, m_secs % 60, m_state, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crono_countdown_ctrl.md
Name: crono_countdown_ctrl

Overview:
- Run-time sequencer for the chronometer adjust datapath. It takes the adjusted preset hh:mm:ss and counts it down to zero on a 1 Hz strobe.
- Handles start/pause/clear from debounced button pulses and drives a timed alarm at expiry.
- Sits between the chronometer adjust block (preset source) and the display/VGA mux.
- Locks out counting while the chronometer adjust switch is active.

Parameters:
- RING_SECS, 10, number of tick_1hz strobes the alarm stays asserted before auto-return to IDLE (1..63).
- MAX_HORA, 15, largest legal hour value; preset hours above this are clamped to it.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-cycle strobe, once per second, synchronous to clk.
- sw_cronometro  in  1  chronometer adjust mode active (level).
- start_stop  in  1  one-cycle pulse; start / pause / resume.
- clear  in  1  one-cycle pulse; abort and return to IDLE.
- alarm_ack  in  1  one-cycle pulse; silence alarm.
- preset_hora  in  4  adjusted hours.
- preset_min  in  6  adjusted minutes.
- preset_seg  in  6  adjusted seconds.
- cnt_hora  out  4  current countdown hours (registered).
- cnt_min  out  6  current countdown minutes (registered).
- cnt_seg  out  6  current countdown seconds (registered).
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- alarm  out  1  high in RING.
- estado  out  2  state code for the display mux.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - cnt_* = 0.
  - ring counter = 0.
  - running, paused and alarm = 0.
  - Release is synchronous to clk.
- Preset sanitising (combinational):
  - min>59 is used as 59; seg>59 is used as 59; hora>MAX_HORA is used as MAX_HORA.
  - "zero preset" means all three sanitised fields are 0.
- Event priority in a single cycle: clear > sw_cronometro lockout > start_stop > tick_1hz.
- States: IDLE=0, RUN=1, PAUSE=2, RING=3.
  - IDLE:
    - cnt_* follow the sanitised preset every cycle; one-cycle latency from preset change to cnt_* output.
    - start_stop with sw_cronometro=0 and non-zero preset -> RUN; cnt_* hold the loaded preset.
    - start_stop with zero preset or sw_cronometro=1 is ignored.
  - RUN:
    - On tick_1hz, decrement with borrow:
      - seg>0: seg-1.
      - otherwise seg=59 and min borrows: min>0: min-1; otherwise min=59 and hora-1.
    - Result is visible on cnt_* the cycle after the tick.
    - If the decremented value is 00:00:00 -> RING in the same update; ring counter cleared.
    - start_stop -> PAUSE; a tick in that same cycle is dropped.
    - sw_cronometro=1 -> PAUSE.
    - clear -> IDLE.
  - PAUSE:
    - cnt_* frozen; ticks ignored.
    - start_stop with sw_cronometro=0 -> RUN.
    - clear -> IDLE.
    - Preset changes do not affect cnt_*.
  - RING:
    - alarm=1; cnt_* held at 0.
    - Each tick increments the ring counter; the tick that makes it equal RING_SECS -> IDLE.
    - alarm_ack, clear or start_stop -> IDLE immediately.
    - sw_cronometro is ignored.
- Outputs:
  - running = (state==RUN); paused = (state==PAUSE); alarm = (state==RING); estado = state code.
  - All are registered and change in the same cycle as the state register.
- 00:00:00 is never decremented; underflow is impossible by construction.
- Reset mid-RUN or mid-RING: immediate return to reset values; no alarm glitch after release.

Decomposition:
- Shared package holds:
  - state encodings IDLE/RUN/PAUSE/RING (2-bit);
  - constants MAX_MIN=59 and MAX_SEG=59;
  - field widths HORA_W=4 and MS_W=6.
- One natural sub-module: crono_borrow_dec. It is a purely combinational hh:mm:ss decrement-with-borrow that also emits a zero flag, and it is reused by future timer/alarm blocks.
- The FSM, ring counter and registers stay in the top module.

Test Plan:
- Reset then preset 00:01:05, start_stop, 6 ticks -> cnt shows 00:00:59 one cycle after the 6th tick; running=1.
- Preset 01:00:00 in RUN, 1 tick -> 00:59:59 (double borrow).
- Preset 00:00:02, start, 2 ticks -> alarm=1 the cycle after the 2nd tick, cnt=00:00:00; then 10 ticks -> IDLE, alarm=0; with RING_SECS=10 the alarm lasts exactly 10 ticks.
- In RUN at 00:00:30, start_stop and tick asserted in the same cycle -> PAUSE, cnt stays 00:00:30; 5 more ticks -> unchanged; start_stop -> RUN; next tick -> 00:00:29.
- Zero preset + start_stop -> stays IDLE.
- Preset min=63 -> cnt_min shows 59.
- sw_cronometro=1 during RUN -> PAUSE.
- clear and start_stop asserted together in PAUSE -> IDLE.
- rst pulled low mid-RING, asynchronous to clk -> alarm=0 and cnt=0 without waiting for a clk edge; after release -> IDLE.
